// File: rtl/mult_arbiter_if.sv
// Bundles the requester handshake, the shared multiplier connection and the response bus of mult_arbiter.
interface mult_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_x;
    logic [16*NUM_REQ-1:0] req_y;
    logic [15:0]           mul_x;
    logic [15:0]           mul_y;
    logic [31:0]           mul_res;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_data;

    // Environment side: clients plus the shared multiplier result.
    modport master (
        output req_valid, req_x, req_y, mul_res,
        input  req_ready, mul_x, mul_y, rsp_valid, rsp_id, rsp_data
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_x, req_y, mul_res,
        output req_ready, mul_x, mul_y, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin front end for one shared pipelined 16x16 multiplier; routes each product back to its requester.
// Defining MULT_ARB_STATS_EN adds the issue_cnt and busy status ports.
module mult_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int PIPE_LAT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    mult_arbiter_if.slave bus
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [15:0]   issue_cnt,
    output logic          busy
`endif
);
    localparam int          NSTG   = PIPE_LAT + 1;
    localparam int unsigned NREQ_U = NUM_REQ;

    logic [ID_W-1:0]            ptr_q;
    logic [ID_W-1:0]            ptr_d;
    logic [15:0]                mul_x_q;
    logic [15:0]                mul_x_d;
    logic [15:0]                mul_y_q;
    logic [15:0]                mul_y_d;
    logic [NSTG-1:0]            tag_vld_q;
    logic [NSTG-1:0]            tag_vld_d;
    logic [NSTG-1:0][ID_W-1:0]  tag_id_q;
    logic [NSTG-1:0][ID_W-1:0]  tag_id_d;

    logic [NUM_REQ-1:0]         grant_s;
    logic [ID_W-1:0]            gnt_idx_s;
    logic                       gnt_any_s;
    logic [ID_W-1:0]            cand_s;
    logic                       hit_s;
    logic [NUM_REQ-1:0]         rsp_valid_s;
    logic [ID_W-1:0]            rsp_id_s;
    logic [31:0]                rsp_data_s;

    // Modular add on the requester ring; both operands are already below NUM_REQ.
    function automatic logic [ID_W-1:0] ring_add(input logic [ID_W-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NREQ_U) begin
            sum = sum - NREQ_U;
        end else begin
            sum = sum;
        end
        return sum[ID_W-1:0];
    endfunction

    // Search upward from the pointer with wrap-around; the first valid requester wins.
    always_comb begin
        grant_s   = '0;
        gnt_idx_s = '0;
        gnt_any_s = 1'b0;
        cand_s    = '0;
        hit_s     = 1'b0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            cand_s           = ring_add(ptr_q, k);
            hit_s            = !gnt_any_s && bus.req_valid[cand_s];
            grant_s[cand_s]  = grant_s[cand_s] | hit_s;
            gnt_idx_s        = hit_s ? cand_s : gnt_idx_s;
            gnt_any_s        = gnt_any_s | hit_s;
        end
    end

    // Pointer advance, operand capture and tag shift for the next cycle.
    always_comb begin
        ptr_d     = ptr_q;
        mul_x_d   = mul_x_q;
        mul_y_d   = mul_y_q;
        tag_vld_d = {tag_vld_q[NSTG-2:0], gnt_any_s};
        tag_id_d  = {tag_id_q[NSTG-2:0], gnt_idx_s};
        if (gnt_any_s) begin
            ptr_d   = ring_add(gnt_idx_s, 32'd1);
            mul_x_d = bus.req_x[32'(gnt_idx_s)*16 +: 16];
            mul_y_d = bus.req_y[32'(gnt_idx_s)*16 +: 16];
        end else begin
            ptr_d   = ptr_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            mul_x_q   <= 16'h0000;
            mul_y_q   <= 16'h0000;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            mul_x_q   <= mul_x_d;
            mul_y_q   <= mul_y_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    // The last tag stage lines up with the multiplier result of the same operands.
    always_comb begin
        rsp_valid_s = '0;
        rsp_id_s    = '0;
        rsp_data_s  = 32'h0000_0000;
        if (tag_vld_q[NSTG-1]) begin
            rsp_valid_s[tag_id_q[NSTG-1]] = 1'b1;
            rsp_id_s                      = tag_id_q[NSTG-1];
            rsp_data_s                    = bus.mul_res;
        end else begin
            rsp_valid_s = '0;
        end
    end

    // Grant is forced low while reset is held so nothing looks accepted.
    assign bus.req_ready = grant_s & {NUM_REQ{rst_n}};
    assign bus.mul_x     = mul_x_q;
    assign bus.mul_y     = mul_y_q;
    assign bus.rsp_valid = rsp_valid_s;
    assign bus.rsp_id    = rsp_id_s;
    assign bus.rsp_data  = rsp_data_s;

`ifdef MULT_ARB_STATS_EN
    logic [15:0] issue_cnt_q;
    logic [15:0] issue_cnt_d;

    // Saturating count of accepted handshakes.
    always_comb begin
        issue_cnt_d = issue_cnt_q;
        if (gnt_any_s && (issue_cnt_q != 16'hFFFF)) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
        end else begin
            issue_cnt_d = issue_cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= 16'h0000;
        end else begin
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign busy      = |tag_vld_q;
`endif
endmodule
